seven_segment_mux: RTL and testbench

//  Output-side partner to the switch-input adder. Drives a dual common-anode seven-segment display

---
 rtl/seven_segment_pkg.sv | 25 ++
 rtl/seven_segment_decoder.sv | 32 +++
 rtl/seven_segment_mux.sv | 126 ++++++++++++
 tb/tb_seven_segment_mux.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
package seven_segment_pkg;

  // Slot sequence: BLANK1 -> DIGIT0 -> BLANK0 -> DIGIT1 -> BLANK1 ...
  typedef enum logic [1:0] {
    BLANK1 = 2'd0,
    DIGIT0 = 2'd1,
    BLANK0 = 2'd2,
    DIGIT1 = 2'd3
  } mux_state_t;

  // Active-low segment bus {g,f,e,d,c,b,a}: all ones means every segment dark
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low anode enables; bit 0 drives digit0, bit 1 drives digit1
  localparam logic [1:0] ANODE_OFF = 2'b11;
  localparam logic [1:0] ANODE_D0  = 2'b10;
  localparam logic [1:0] ANODE_D1  = 2'b01;

  // True for the two lit slots, false for the blanking guards
  function automatic logic is_digit_state(input mux_state_t s);
    return (s == DIGIT0) || (s == DIGIT1);
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational so it can be dropped in front of any output register.
module seven_segment_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup; lower-case b and d keep them distinct from 8 and 0
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Dual-digit common-anode display driver. The two hex digits come from the
// active-low DIP switches (digit0 = ~switch[3:0], digit1 = ~switch[7:4]) and
// share one segment bus, with a blanking guard between slots to stop ghosting.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switch,
  output logic [6:0] seg,
  output logic [1:0] anode
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // Two-stage synchroniser for the asynchronous switch inputs
  logic [7:0] sw_meta_d, sw_meta_q;
  logic [7:0] sw_s_d,    sw_s_q;

  // Slot sequencer and registered display outputs
  mux_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;
  logic [1:0]       anode_d, anode_q;
  logic [6:0]       seg_d,   seg_q;

  logic [CNT_W-1:0] slot_last;
  logic [3:0]       digit_nibble [2];
  logic [6:0]       digit_seg    [2];

  // Synchroniser next-state: stage 1 samples the pins, stage 2 follows stage 1
  always_comb begin
    sw_meta_d = switch;
    sw_s_d    = sw_meta_q;
  end

  // Synchroniser flops; reset to all-ones so both digits read as 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= 8'hFF;
      sw_s_q    <= 8'hFF;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_s_q    <= sw_s_d;
    end
  end

  // One decoder per digit, fed by the inverted (active-high) switch nibble
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      assign digit_nibble[gi] = ~sw_s_q[gi*4 +: 4];

      seven_segment_decoder u_decoder (
        .nibble (digit_nibble[gi]),
        .seg    (digit_seg[gi])
      );
    end
  endgenerate

  // Sequencer next-state: count through the slot, advance on its last cycle,
  // and load the outputs only when a new slot begins so a digit stays frozen
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    anode_d   = anode_q;
    seg_d     = seg_q;
    slot_last = is_digit_state(state_q) ? DIGIT_LAST : BLANK_LAST;

    if (cnt_q > slot_last) begin
      // Counter outside the current slot's range: resynchronise at BLANK1
      state_d = BLANK1;
      cnt_d   = '0;
      anode_d = ANODE_OFF;
      seg_d   = SEG_OFF;
    end else if (cnt_q == slot_last) begin
      cnt_d = '0;
      case (state_q)
        BLANK1:  state_d = DIGIT0;
        DIGIT0:  state_d = BLANK0;
        BLANK0:  state_d = DIGIT1;
        DIGIT1:  state_d = BLANK1;
        default: state_d = BLANK1;
      endcase

      case (state_d)
        DIGIT0: begin
          anode_d = ANODE_D0;
          seg_d   = digit_seg[0];
        end
        DIGIT1: begin
          anode_d = ANODE_D1;
          seg_d   = digit_seg[1];
        end
        default: begin
          anode_d = ANODE_OFF;
          seg_d   = SEG_OFF;
        end
      endcase
    end
  end

  // Sequencer state, slot counter and output registers; reset blanks the display at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux with a short refresh period
// (8 lit cycles, 2 blank cycles, 20-cycle frame).
module tb_seven_segment_mux;

  localparam int REFRESH_DIV  = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int WAIT_BUDGET  = 60;

  logic       clk;
  logic       reset;
  logic [7:0] switch;
  logic [6:0] seg;
  logic [1:0] anode;

  int checks;
  int fails;

  logic [6:0] seg_tbl [16];

  seven_segment_mux #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .switch (switch),
    .seg    (seg),
    .anode  (anode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous invariants, sampled on the inactive edge
  always @(negedge clk) begin
    checks++;
    if (anode === 2'b00) begin
      fails++;
      $display("FAIL invariant_anode: anode=%b, must never be 00", anode);
    end else if (anode === 2'b11 && seg !== 7'h7F) begin
      fails++;
      $display("FAIL invariant_blank: anode=11 seg=%b, required 1111111", seg);
    end
  end

  // Wait (bounded) until anode changes into the target value; returns on that sample
  task automatic wait_enter(input logic [1:0] target, input string tag);
    logic [1:0] prev;
    bit         found;
    prev  = anode;
    found = 1'b0;
    for (int i = 0; i < WAIT_BUDGET && !found; i++) begin
      @(negedge clk);
      if (anode === target && prev !== target) found = 1'b1;
      prev = anode;
    end
    if (!found) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: anode never entered %b within %0d cycles, last=%b",
               tag, target, WAIT_BUDGET, anode);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    switch = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if (anode !== 2'b11 || seg !== 7'h7F) begin
      fails++;
      $display("FAIL reset_hold: anode=%b seg=%b, required 11 1111111", anode, seg);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (anode !== 2'b11) begin
      fails++;
      $display("FAIL reset_edge1: anode=%b, required 11", anode);
    end
    @(negedge clk);
    checks++;
    if (anode !== 2'b10 || seg !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_edge2: anode=%b seg=%b, required 10 1000000", anode, seg);
    end
    $display("test_reset: done, checks=%0d fails=%0d", checks, fails);
  endtask

  task automatic test_digits();
    switch = 8'b0100_1111;
    wait_enter(2'b10, "digits_d0");
    for (int i = 0; i < REFRESH_DIV; i++) begin
      checks++;
      if (anode !== 2'b10 || seg !== 7'b1000000) begin
        fails++;
        $display("FAIL digits_d0[%0d]: anode=%b seg=%b, required 10 1000000", i, anode, seg);
      end
      @(negedge clk);
    end
    checks++;
    if (anode !== 2'b11) begin
      fails++;
      $display("FAIL digits_d0_len: anode=%b after %0d cycles, required 11", anode, REFRESH_DIV);
    end
    wait_enter(2'b01, "digits_d1");
    for (int i = 0; i < REFRESH_DIV; i++) begin
      checks++;
      if (anode !== 2'b01 || seg !== 7'b0000011) begin
        fails++;
        $display("FAIL digits_d1[%0d]: anode=%b seg=%b, required 01 0000011", i, anode, seg);
      end
      @(negedge clk);
    end
    checks++;
    if (anode !== 2'b11) begin
      fails++;
      $display("FAIL digits_d1_len: anode=%b after %0d cycles, required 11", anode, REFRESH_DIV);
    end
    $display("test_digits: switch=%b done, checks=%0d fails=%0d", switch, checks, fails);
  endtask

  task automatic test_blanking();
    for (int b = 0; b < 10; b++) begin
      wait_enter(2'b11, "blank");
      for (int i = 0; i < BLANK_CYCLES; i++) begin
        checks++;
        if (anode !== 2'b11 || seg !== 7'h7F) begin
          fails++;
          $display("FAIL blank[%0d.%0d]: anode=%b seg=%b, required 11 1111111", b, i, anode, seg);
        end
        @(negedge clk);
      end
      checks++;
      if (anode === 2'b11) begin
        fails++;
        $display("FAIL blank_len[%0d]: anode=%b after %0d cycles, required a digit", b, anode, BLANK_CYCLES);
      end
    end
    $display("test_blanking: 10 guards done, checks=%0d fails=%0d", checks, fails);
  endtask

  task automatic test_freeze();
    switch = 8'hFF;
    wait_enter(2'b11, "freeze_pre");
    wait_enter(2'b10, "freeze_d0");
    repeat (3) @(negedge clk);
    switch = 8'h00;
    for (int i = 3; i < REFRESH_DIV; i++) begin
      checks++;
      if (anode !== 2'b10 || seg !== 7'b1000000) begin
        fails++;
        $display("FAIL freeze_hold[%0d]: anode=%b seg=%b, required 10 1000000", i, anode, seg);
      end
      @(negedge clk);
    end
    wait_enter(2'b01, "freeze_d1a");
    checks++;
    if (seg !== 7'b0001110) begin
      fails++;
      $display("FAIL freeze_d1a: seg=%b, required 0001110", seg);
    end
    wait_enter(2'b10, "freeze_d0b");
    checks++;
    if (seg !== 7'b0001110) begin
      fails++;
      $display("FAIL freeze_d0b: seg=%b, required 0001110", seg);
    end
    wait_enter(2'b01, "freeze_d1b");
    checks++;
    if (seg !== 7'b0001110) begin
      fails++;
      $display("FAIL freeze_d1b: seg=%b, required 0001110", seg);
    end
    $display("test_freeze: done, checks=%0d fails=%0d", checks, fails);
  endtask

  task automatic test_async_reset();
    wait_enter(2'b01, "areset_d1");
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (anode !== 2'b11 || seg !== 7'h7F) begin
      fails++;
      $display("FAIL areset_immediate: anode=%b seg=%b, required 11 1111111", anode, seg);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (anode !== 2'b11) begin
      fails++;
      $display("FAIL areset_edge1: anode=%b, required 11", anode);
    end
    @(negedge clk);
    checks++;
    if (anode !== 2'b10) begin
      fails++;
      $display("FAIL areset_edge2: anode=%b, required 10", anode);
    end
    $display("test_async_reset: done, checks=%0d fails=%0d", checks, fails);
  endtask

  task automatic test_sweep();
    logic [3:0] d0;
    logic [3:0] d1;
    for (int v = 0; v < 16; v++) begin
      d0     = 4'(v);
      d1     = 4'(15 - v);
      switch = ~{d1, d0};
      wait_enter(2'b11, "sweep_pre");
      wait_enter(2'b10, "sweep_d0");
      checks++;
      if (seg !== seg_tbl[d0]) begin
        fails++;
        $display("FAIL sweep_d0[%h]: seg=%b, required %b", d0, seg, seg_tbl[d0]);
      end
      wait_enter(2'b01, "sweep_d1");
      checks++;
      if (seg !== seg_tbl[d1]) begin
        fails++;
        $display("FAIL sweep_d1[%h]: seg=%b, required %b", d1, seg, seg_tbl[d1]);
      end
      $display("test_sweep: digit0=%h digit1=%h checked", d0, d1);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    switch = 8'hFF;
    seg_tbl[0]  = 7'b1000000;
    seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100;
    seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001;
    seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010;
    seg_tbl[7]  = 7'b1111000;
    seg_tbl[8]  = 7'b0000000;
    seg_tbl[9]  = 7'b0010000;
    seg_tbl[10] = 7'b0001000;
    seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110;
    seg_tbl[13] = 7'b0100001;
    seg_tbl[14] = 7'b0000110;
    seg_tbl[15] = 7'b0001110;

    test_reset();
    test_digits();
    test_blanking();
    test_freeze();
    test_async_reset();
    test_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
